// File: rtl/master_out_port_if.sv
// Signal bundle between the master core, master_out_port and the serial system bus.
// The master modport is the transmitter's view; the slave modport is the core/bus side.
interface master_out_port_if #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int BURST_W = 13
);
    logic               start;
    logic               mode;
    logic [ADDR_W-1:0]  addr_in;
    logic [DATA_W-1:0]  data_in;
    logic [BURST_W-1:0] burst_in;
    logic               slave_ready;
    logic               master_valid;
    logic               write_en;
    logic               read_en;
    logic               tx_addr;
    logic               tx_data;
    logic [BURST_W-1:0] burst;
    logic               data_req;
    logic               busy;
    logic               tx_done;

    modport master (
        input  start, mode, addr_in, data_in, burst_in, slave_ready,
        output master_valid, write_en, read_en, tx_addr, tx_data, burst, data_req, busy, tx_done
    );

    modport slave (
        output start, mode, addr_in, data_in, burst_in, slave_ready,
        input  master_valid, write_en, read_en, tx_addr, tx_data, burst, data_req, busy, tx_done
    );
endinterface

// File: rtl/master_out_port.sv
// Bit-serial master-side bus transmitter: request strobe, LSB-first address/data lanes, burst writes.
// Optional macro TX_PARITY_EN appends an even-parity cycle to the address phase and to every data beat.
//
// state | meaning
// IDLE  | waiting for start together with slave_ready
// REQ   | one-cycle master_valid with write_en/read_en
// ADDR  | address bits on tx_addr, first write byte on tx_data
// DATA  | further burst write beats on tx_data
// DONE  | one-cycle tx_done, then back to IDLE
module master_out_port #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int BURST_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    master_out_port_if.master bus
);
`ifdef TX_PARITY_EN
    localparam int PAR_LEN = 1;
`else
    localparam int PAR_LEN = 0;
`endif
    localparam int ADDR_LEN = ADDR_W + PAR_LEN;
    localparam int BEAT_LEN = DATA_W + PAR_LEN;
    localparam int CNT_W    = $clog2(ADDR_LEN + BEAT_LEN);
    localparam int BEAT_W   = BURST_W - 1;

    typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                mode_r;
    logic [ADDR_LEN-1:0] addr_sr;
    logic [BEAT_LEN-1:0] data_sr;
    logic [BURST_W-1:0]  burst_r;
    logic [BEAT_W-1:0]   beats_left;
    logic [CNT_W-1:0]    bit_cnt;
    logic                bit_tc;
    logic                data_req;
    logic                shifting;

    // Parity (when enabled) rides as the top bit so it falls out after the payload bits.
    function automatic logic [ADDR_LEN-1:0] frame_addr(input logic [ADDR_W-1:0] a);
`ifdef TX_PARITY_EN
        return {^a, a};
`else
        return a;
`endif
    endfunction

    function automatic logic [BEAT_LEN-1:0] frame_byte(input logic [DATA_W-1:0] d);
`ifdef TX_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // Beats still to send after the first; a zero count with burst enabled means one beat.
    function automatic logic [BEAT_W-1:0] extra_beats(input logic [BURST_W-1:0] b);
        logic [BEAT_W-1:0] n;
        n = b[BURST_W-1] ? b[BEAT_W-1:0] : BEAT_W'(1);
        if (n == '0) n = BEAT_W'(1);
        return n - BEAT_W'(1);
    endfunction

    assign bit_tc   = (bit_cnt == '0);
    assign shifting = (state == ADDR) || (state == DATA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        data_req  = 1'b0;
        case (state)
            IDLE: if (bus.start && bus.slave_ready) state_nxt = REQ;
            REQ:  state_nxt = ADDR;
            ADDR: begin
                if (bit_tc) begin
                    if (mode_r && (beats_left != '0)) begin
                        data_req  = 1'b1;
                        state_nxt = DATA;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DATA: begin
                if (bit_tc) begin
                    if (beats_left != '0) data_req  = 1'b1;
                    else                  state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_r     <= 1'b0;
            addr_sr    <= '0;
            data_sr    <= '0;
            burst_r    <= '0;
            beats_left <= '0;
            bit_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nxt == REQ) begin
                        mode_r     <= bus.mode;
                        addr_sr    <= frame_addr(bus.addr_in);
                        data_sr    <= bus.mode ? frame_byte(bus.data_in) : '0;
                        burst_r    <= bus.burst_in;
                        beats_left <= extra_beats(bus.burst_in);
                    end
                end
                REQ: bit_cnt <= CNT_W'(ADDR_LEN - 1);
                ADDR, DATA: begin
                    addr_sr <= addr_sr >> 1;
                    data_sr <= data_sr >> 1;
                    if (bit_tc) bit_cnt <= CNT_W'(BEAT_LEN - 1);
                    else        bit_cnt <= bit_cnt - CNT_W'(1);
                    if (data_req) begin
                        data_sr    <= frame_byte(bus.data_in);
                        beats_left <= beats_left - BEAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.master_valid = (state == REQ);
    assign bus.write_en     = (state == REQ) && mode_r;
    assign bus.read_en      = (state == REQ) && !mode_r;
    assign bus.tx_addr      = (state == ADDR) && addr_sr[0];
    assign bus.tx_data      = shifting && data_sr[0];
    assign bus.burst        = shifting ? burst_r : '0;
    assign bus.data_req     = data_req;
    assign bus.busy         = (state != IDLE);
    assign bus.tx_done      = (state == DONE);
endmodule

// File: tb/tb_master_out_port.sv
// Scoreboard bench for master_out_port: stimulus queues per-cycle expected frames, a negedge monitor compares.
module tb_master_out_port;
`ifdef TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LEN1 = (PAR == 1) ? 15 : 14;
    localparam int BEAT = (PAR == 1) ? 9 : 8;

    typedef struct packed {
        logic        mv;
        logic        we;
        logic        re;
        logic        ta;
        logic        td;
        logic [12:0] bu;
        logic        dr;
        logic        by;
        logic        dn;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    master_out_port_if bus ();
    master_out_port dut (.clk(clk), .reset(rst_n), .bus(bus));

    always #5 clk = ~clk;

    obs_t       exp_q[$];
    int         len_q[$];
    logic [7:0] frame_bytes[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;

    function automatic obs_t sample_obs();
        obs_t o;
        o.mv = bus.master_valid;
        o.we = bus.write_en;
        o.re = bus.read_en;
        o.ta = bus.tx_addr;
        o.td = bus.tx_data;
        o.bu = bus.burst;
        o.dr = bus.data_req;
        o.by = bus.busy;
        o.dn = bus.tx_done;
        return o;
    endfunction

    // Monitor: every busy cycle consumes one expected vector; idle cycles must be all-zero.
    always @(negedge clk) begin
        obs_t got;
        obs_t want;
        int   l;
        if (!rst_n) begin
            cyc = 0;
        end else begin
            got = sample_obs();
            n_vec++;
            if (got.by) begin
                cyc = got.mv ? 1 : cyc + 1;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_busy cyc=%0d got=%h want=idle", cyc, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL frame_cycle cyc=%0d got=%h want=%h", cyc, got, want);
                    end
                end
                if (got.dn) begin
                    n_vec++;
                    if (len_q.size() == 0) begin
                        n_err++;
                        $display("FAIL frame_len got=%0d want=none", cyc);
                    end else begin
                        l = len_q.pop_front();
                        if (cyc != l) begin
                            n_err++;
                            $display("FAIL frame_len got=%0d want=%0d", cyc, l);
                        end
                    end
                end
            end else if (got !== '0) begin
                n_err++;
                $display("FAIL idle_outputs got=%h want=0", got);
            end
        end
    end

    task automatic check_zero(input string name);
        obs_t got;
        got = sample_obs();
        n_vec++;
        if (got !== '0) begin
            n_err++;
            $display("FAIL %s got=%h want=0", name, got);
        end
    endtask

    task automatic build_expect(input logic m, input logic [11:0] a, input logic [12:0] b);
        obs_t       o;
        int         n;
        logic [7:0] d;
        n = b[12] ? int'(b[11:0]) : 1;
        if (n == 0) n = 1;
        o = '0; o.mv = 1'b1; o.we = m; o.re = ~m; o.by = 1'b1;
        exp_q.push_back(o);
        d = frame_bytes[0];
        for (int k = 0; k < 12 + PAR; k++) begin
            o = '0; o.by = 1'b1; o.bu = b;
            o.ta = (k < 12) ? a[k] : ^a;
            if (m) o.td = (k < 8) ? d[k] : ((k == 8 && PAR == 1) ? ^d : 1'b0);
            o.dr = (k == 11 + PAR) && m && (n > 1);
            exp_q.push_back(o);
        end
        if (m) begin
            for (int j = 1; j < n; j++) begin
                d = frame_bytes[j];
                for (int i = 0; i < BEAT; i++) begin
                    o = '0; o.by = 1'b1; o.bu = b;
                    o.td = (i < 8) ? d[i] : ^d;
                    o.dr = (i == BEAT - 1) && (j < n - 1);
                    exp_q.push_back(o);
                end
            end
        end
        o = '0; o.by = 1'b1; o.dn = 1'b1;
        exp_q.push_back(o);
    endtask

    task automatic run_frame(input logic m, input logic [11:0] a, input logic [12:0] b,
                             input int exp_len, input int sr_delay, input int pulse_at,
                             input int abort_at);
        int c;
        int bi;
        bit seen;
        build_expect(m, a, b);
        len_q.push_back(exp_len);
        bi = 1;
        @(negedge clk);
        bus.mode     = m;
        bus.addr_in  = a;
        bus.burst_in = b;
        bus.data_in  = frame_bytes[0];
        bus.start    = 1'b1;
        if (sr_delay > 0) begin
            bus.slave_ready = 1'b0;
            repeat (sr_delay) @(negedge clk);
            bus.slave_ready = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.busy;
        end
        bus.start = 1'b0;
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL start_timeout busy=0 want=1");
            return;
        end
        c = 1;
        while (bus.busy && c <= exp_len + 20) begin
            if (c == abort_at) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1 check_zero("async_reset_outputs");
                exp_q.delete();
                len_q.delete();
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (bus.data_req && bi < frame_bytes.size()) begin
                bus.data_in = frame_bytes[bi];
                bi++;
            end
            bus.start = (c == pulse_at);
            @(negedge clk);
            c++;
        end
        bus.start = 1'b0;
        n_vec++;
        if (bus.busy) begin
            n_err++;
            $display("FAIL frame_timeout busy=1 want=0 after %0d cycles", c);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout sim_time=%0t want=finish_earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = 1'b0;
        bus.mode        = 1'b0;
        bus.addr_in     = '0;
        bus.data_in     = '0;
        bus.burst_in    = '0;
        bus.slave_ready = 1'b1;
        #1 check_zero("reset_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single write: alternating address and data bits
        frame_bytes = '{8'h55};
        run_frame(1'b1, 12'hAAA, 13'h0000, LEN1, 0, 0, 0);

        // read: tx_data stays low even though data_in is non-zero
        frame_bytes = '{8'hC3};
        run_frame(1'b0, 12'h123, 13'h0000, LEN1, 0, 0, 0);

        // three-beat burst write
        frame_bytes = '{8'h55, 8'h0F, 8'hF0};
        run_frame(1'b1, 12'h5A5, 13'h1003, (PAR == 1) ? 33 : 30, 0, 0, 0);

        // burst descriptor on a read never enters DATA
        frame_bytes = '{8'hA5};
        run_frame(1'b0, 12'h7E1, 13'h1005, LEN1, 0, 0, 0);

        // burst enabled with count 0 behaves as one beat
        frame_bytes = '{8'h3C};
        run_frame(1'b1, 12'hF00, 13'h1000, LEN1, 0, 0, 0);

        // count without burst enable is a single beat
        frame_bytes = '{8'h81};
        run_frame(1'b1, 12'h00F, 13'h0007, LEN1, 0, 0, 0);

        // slave_ready low for 5 cycles, then start pulse while busy
        frame_bytes = '{8'h96};
        run_frame(1'b1, 12'h5A5, 13'h0000, LEN1, 5, 5, 0);
        repeat (4) @(negedge clk);

        // asynchronous reset mid-frame, stay idle, then a fresh frame
        frame_bytes = '{8'hFF};
        run_frame(1'b1, 12'h3C3, 13'h0000, LEN1, 0, 0, 5);
        repeat (20) @(negedge clk);
        frame_bytes = '{8'h81};
        run_frame(1'b1, 12'h0F0, 13'h0000, LEN1, 0, 0, 0);

`ifdef TX_PARITY_EN
        // address parity on the extra address cycle
        frame_bytes = '{8'h03};
        run_frame(1'b1, 12'h001, 13'h0000, 15, 0, 0, 0);
`endif

        // maximum beat count must not wrap
        frame_bytes.delete();
        for (int i = 0; i < 4095; i++) frame_bytes.push_back(8'(i * 37 + 11));
        run_frame(1'b1, 12'hC35, 13'h1FFF, LEN1 + 4094 * BEAT, 0, 0, 0);

        repeat (5) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0 || len_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected got=%0d/%0d want=0/0", exp_q.size(), len_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/master_out_port.md
Name: master_out_port

Overview:
- Bit-serial transmitter on the master side of the system bus. It drives the same serial address/data lanes and request strobes that slave_in_port receives.
- Accepts a parallel request from the master core: address, write byte, read/write mode, burst descriptor.
- Issues the one-cycle request strobe, then serialises the 12-bit address and the 8-bit write data, both LSB first.
- For burst writes, streams the additional data beats and fetches each next byte from the core with a data_req handshake.

Parameters:
ADDR_W, 12, address width; number of address-phase cycles
DATA_W, 8, data width; bits per data beat
BURST_W, 13, burst descriptor width; MSB = burst enable, low BURST_W-1 bits = beat count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  level request from master core; held until busy rises
mode  in  1  1 = write, 0 = read; sampled with start
addr_in  in  ADDR_W  transfer start address; sampled with start
data_in  in  DATA_W  first write byte (sampled with start); later burst bytes (sampled when data_req=1)
burst_in  in  BURST_W  burst descriptor; sampled with start
slave_ready  in  1  slave can accept a new request
master_valid  out  1  one-cycle request strobe
write_en  out  1  one-cycle write strobe, coincident with master_valid
read_en  out  1  one-cycle read strobe, coincident with master_valid
tx_addr  out  1  serial address lane
tx_data  out  1  serial write-data lane
burst  out  BURST_W  latched burst descriptor; 0 outside ADDR/DATA
data_req  out  1  pulse; core must present the next burst byte on data_in this cycle
busy  out  1  high from acceptance until tx_done
tx_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0. Internal shift registers and counters cleared. This applies at any point, including mid-transfer. No partial frame resumes after reset is released.
- Cycle numbering: T0 is the edge where IDLE samples start=1 and slave_ready=1. In that case the block latches mode, addr_in, data_in, burst_in, and busy goes 1. If start=1 and slave_ready=0, the block stays in IDLE.
- State REQ, T1: master_valid=1 for exactly one cycle. write_en=mode, read_en=~mode.
- State ADDR, T2..T13 (ADDR_W cycles):
  - tx_addr = addr[k] at cycle T2+k.
  - Writes: tx_data = data[k] for k<DATA_W, 0 afterwards.
  - Reads: tx_data = 0.
  - burst = latched descriptor, held through ADDR and DATA.
- Beat count N:
  - N = burst[11:0] when burst[12]=1; N=0 is treated as 1.
  - N = 1 when burst[12]=0.
  - Reads never enter DATA, whatever the value of N.
- State DATA (writes with N>1 only): beats 2..N, DATA_W cycles each, starting at T14.
  - tx_data carries the byte LSB first; tx_addr = 0.
  - data_req=1 during the last bit cycle of each beat that has a successor: the last ADDR cycle for beat 2, and the last bit of beat j for beat j+1.
  - data_in is captured on the edge where data_req=1.
- State DONE: one cycle after the final serial bit. tx_done=1, busy=0 at the following edge, then back to IDLE. tx_addr, tx_data and burst are 0 in DONE.
- Single transfer total: tx_done at T14. Burst write: tx_done at T14 + 8·(N−1).
- start asserted while busy: ignored, with no queuing. A new transfer can be accepted on the edge after DONE at the earliest.
- slave_ready is checked only in IDLE; it is ignored mid-transfer.
- Beat counter is 12 bits. N=4095 must complete without wrap.

Optional Feature:
Macro TX_PARITY_EN.
- Defined:
  - ADDR phase grows to ADDR_W+1 cycles. The extra final cycle drives even parity of the address on tx_addr.
  - Each data beat grows to DATA_W+1 cycles, with even parity of the byte on tx_data at bit index DATA_W. Read transfers drive tx_data=0.
  - data_req moves to the parity cycle of the preceding beat.
  - Single transfer tx_done at T15. Burst tx_done at T15 + 9·(N−1).
- Undefined: no parity cycles; timing exactly as in Behaviour.

Test Plan:
1. Single write, addr_in=0xAAA, data_in=0x55, burst_in=0 -> master_valid=write_en=1 at T1 only. tx_addr T2..T13 = 0,1,0,1,… tx_data T2..T9 = 1,0,1,0,1,0,1,0 then 0. tx_done at T14. data_req never asserted.
2. Read, mode=0, addr_in=0x123 -> read_en=1 at T1, write_en=0. tx_addr = 0x123 LSB first. tx_data=0 throughout. tx_done at T14.
3. Burst write, burst_in=0x1003, bytes 0x55/0x0F/0xF0 -> burst=0x1003 from T2. data_req at T13 and T21. Beat 2 (0x0F) on T14..T21, beat 3 (0xF0) on T22..T29. tx_done at T30.
4. start=1 with slave_ready=0 for 5 cycles, then slave_ready=1 -> busy and master_valid stay 0 while slave_ready=0. Transfer begins the cycle after slave_ready rises. A start pulse during busy causes no second transfer.
5. reset=0 asserted asynchronously at T6 of a write -> all outputs 0 immediately. After release with start=0 the block stays idle with no tx_done. A fresh start runs a complete frame.
6. TX_PARITY_EN, write addr_in=0x001, data_in=0x03 -> tx_addr=1 at T14 (parity cycle). tx_data=0 at T10 (parity index 8). tx_done at T15.
